// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      DISCARD = 2'd2
   } ifetch_state_t;

   localparam logic [31:0] INSTR_NOP            = 32'h0000_0000;
   localparam logic [31:0] PC_STEP              = 32'd4;
   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory req/ack bus plus the IF/ID valid/ready output, seen from the fetch stage (master).
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;

   modport master (
      output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
      input  imem_ack, imem_rdata, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
      output imem_ack, imem_rdata, id_ready
   );
endinterface

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID holding register: single valid/ready slot with load, drain and flush.
module if_id_reg
   import ifetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        drain,
   input  logic        flush,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc,
   output logic        valid,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);
   logic        valid_r;
   logic [31:0] instr_r;
   logic [31:0] pc_r;
   logic [31:0] pc_plus4_r;

   // Slot update: flush beats load beats drain; payload only changes on load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_r    <= 1'b0;
         instr_r    <= INSTR_NOP;
         pc_r       <= 32'h0000_0000;
         pc_plus4_r <= 32'h0000_0000;
      end else if (flush) begin
         valid_r <= 1'b0;
      end else if (load) begin
         valid_r    <= 1'b1;
         instr_r    <= load_instr;
         pc_r       <= load_pc;
         pc_plus4_r <= load_pc + PC_STEP;
      end else if (drain) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign valid    = valid_r;
   assign instr    = instr_r;
   assign pc       = pc_r;
   assign pc_plus4 = pc_plus4_r;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: imem req/ack FSM, next-PC select and IF/ID register.
// Define IFETCH_ALIGN_CHECK_EN to block misaligned fetches with a sticky misalign_fault.
module instr_fetch
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   pc,
   output logic [31:0]   next_pc,
   input  logic          redirect_valid,
   input  logic [31:0]   redirect_target,
   instr_fetch_if.master bus,
   output logic          misalign_fault
);
   ifetch_state_t state_r;
   ifetch_state_t state_nx_s;
   logic          imem_req_r;
   logic          req_nx_s;
   logic [31:0]   imem_addr_r;
   logic [31:0]   addr_nx_s;
   logic          fault_r;
   logic          fault_nx_s;
   logic          fault_set_s;
   logic          pc_ok_s;
   logic          slot_free_s;
   logic          issue_s;
   logic          capture_s;
   logic          id_valid_s;
   logic [31:0]   id_instr_s;
   logic [31:0]   id_pc_s;
   logic [31:0]   id_pc_plus4_s;

   assign slot_free_s = !id_valid_s || bus.id_ready;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign pc_ok_s     = (pc[1:0] == 2'b00);
   assign fault_set_s = (state_r == IDLE) && slot_free_s && !redirect_valid && !pc_ok_s;
`else
   assign pc_ok_s     = 1'b1;
   assign fault_set_s = 1'b0;
`endif

   assign issue_s   = (state_r == IDLE) && slot_free_s && !redirect_valid && pc_ok_s;
   assign capture_s = (state_r == BUSY) && bus.imem_ack && !redirect_valid;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic; an ack always ends the transaction, a redirect without ack must wait it out.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (issue_s) state_nx_s = BUSY;
            else         state_nx_s = IDLE;
         end
         BUSY: begin
            if (bus.imem_ack)        state_nx_s = IDLE;
            else if (redirect_valid) state_nx_s = DISCARD;
            else                     state_nx_s = BUSY;
         end
         DISCARD: begin
            if (bus.imem_ack) state_nx_s = IDLE;
            else              state_nx_s = DISCARD;
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // Output decode: request follows the next state, address latches only on issue.
   always_comb begin
      req_nx_s = (state_nx_s != IDLE);
      if (issue_s) addr_nx_s = word_align(pc);
      else         addr_nx_s = imem_addr_r;
      if (redirect_valid)   fault_nx_s = 1'b0;
      else if (fault_set_s) fault_nx_s = 1'b1;
      else                  fault_nx_s = fault_r;
   end

   // Registered memory request and fault outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_req_r  <= 1'b0;
         imem_addr_r <= 32'h0000_0000;
         fault_r     <= 1'b0;
      end else begin
         imem_req_r  <= req_nx_s;
         imem_addr_r <= addr_nx_s;
         fault_r     <= fault_nx_s;
      end
   end

   // Next PC for ProgramCounter: redirect > sequential after capture > hold.
   always_comb begin
      if (reset)               next_pc = RESET_VECTOR;
      else if (redirect_valid) next_pc = redirect_target;
      else if (capture_s)      next_pc = imem_addr_r + PC_STEP;
      else                     next_pc = pc;
   end

   if_id_reg u_if_id (
      .clk        (clk),
      .reset      (reset),
      .load       (capture_s),
      .drain      (bus.id_ready),
      .flush      (redirect_valid),
      .load_instr (bus.imem_rdata),
      .load_pc    (imem_addr_r),
      .valid      (id_valid_s),
      .instr      (id_instr_s),
      .pc         (id_pc_s),
      .pc_plus4   (id_pc_plus4_s)
   );

   assign bus.imem_req    = imem_req_r;
   assign bus.imem_addr   = imem_addr_r;
   assign bus.id_valid    = id_valid_s;
   assign bus.id_instr    = id_instr_s;
   assign bus.id_pc       = id_pc_s;
   assign bus.id_pc_plus4 = id_pc_plus4_s;
   assign misalign_fault  = fault_r;
endmodule
